ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline, directly upstream of the MEM stage. It holds the ID→EX pipeline register and computes ALU results. It drives the data SRAM request for loads and stores and owns the HI/LO registers. It also contains a 32-cycle iterative divider that stalls the pipeline while it runs. It produces the 76-bit EX→MEM bus and a forwarding bus back to ID.

---
 rtl/ex_stage_if.sv | 24 ++
 rtl/ex_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Signal bundle between the execute stage and its neighbours (ID, MEM, data SRAM, stall control).
interface ex_stage_if;
    logic [5:0]   stall;
    logic [144:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
        input  data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
        output data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data SRAM request, HI/LO with
// single-cycle multiplier and a 32-step iterative restoring divider.
module ex_stage (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    localparam int ID_TO_EX_WD  = 145;
    localparam int EX_TO_MEM_WD = 76;
    localparam int StallBus     = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    logic [ID_TO_EX_WD-1:0] id_ex_r;
    logic [StallBus-1:0]    stall_s;
    logic [31:0] pc_s, src1_s, src2_s, store_data_s, sum_s, alu_res_s, ex_result_s;
    logic [3:0]  alu_op_s, md_op_s, wen_s;
    logic        mem_en_s, mem_we_s, sel_rf_res_s, rf_we_s, unused_s;
    logic [4:0]  rf_waddr_s;

    logic [1:0]  state_r;
    logic [4:0]  cnt_r;
    logic [31:0] rem_r, quot_r, divisor_r, hi_r, lo_r;
    logic        quot_neg_r, rem_neg_r;
    logic        div_op_s, div_signed_s, div_zero_s;
    logic [31:0] abs1_s, abs2_s, quot_res_s, rem_res_s, hi_rd_s, lo_rd_s, hi_nxt_s, lo_nxt_s;
    logic [32:0] shifted_s, trial_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;

    assign stall_s  = bus.stall;
    assign unused_s = ^{stall_s[5:4], stall_s[1:0]};

    // ID/EX pipeline register: bubble when ID stops but EX moves on
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_r <= '0;
        end else if (stall_s[2] && !stall_s[3]) begin
            id_ex_r <= '0;
        end else if (!stall_s[2]) begin
            id_ex_r <= bus.id_to_ex_bus;
        end else begin
            id_ex_r <= id_ex_r;
        end
    end

    assign {pc_s, alu_op_s, src1_s, src2_s, mem_en_s, mem_we_s, sel_rf_res_s,
            rf_we_s, rf_waddr_s, store_data_s, md_op_s} = id_ex_r;

    assign sum_s = src1_s + src2_s;

    // ALU
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_op_s)
            4'd0:    alu_res_s = sum_s;
            4'd1:    alu_res_s = src1_s - src2_s;
            4'd2:    alu_res_s = src1_s & src2_s;
            4'd3:    alu_res_s = src1_s | src2_s;
            4'd4:    alu_res_s = src1_s ^ src2_s;
            4'd5:    alu_res_s = ~(src1_s | src2_s);
            4'd6:    alu_res_s = {31'd0, $signed(src1_s) < $signed(src2_s)};
            4'd7:    alu_res_s = {31'd0, src1_s < src2_s};
            4'd8:    alu_res_s = src2_s << src1_s[4:0];
            4'd9:    alu_res_s = src2_s >> src1_s[4:0];
            4'd10:   alu_res_s = $signed(src2_s) >>> src1_s[4:0];
            4'd11:   alu_res_s = {src2_s[15:0], 16'd0};
            default: alu_res_s = 32'd0;
        endcase
    end

    // Sign/zero extension to 64 bits makes one unsigned multiply serve both MULT and MULTU.
    assign mul_a_s = (md_op_s == MD_MULT) ? {{32{src1_s[31]}}, src1_s} : {32'd0, src1_s};
    assign mul_b_s = (md_op_s == MD_MULT) ? {{32{src2_s[31]}}, src2_s} : {32'd0, src2_s};
    assign prod_s  = mul_a_s * mul_b_s;

    assign div_op_s     = (md_op_s == MD_DIV) || (md_op_s == MD_DIVU);
    assign div_signed_s = (md_op_s == MD_DIV);
    assign div_zero_s   = (src2_s == 32'd0);
    assign abs1_s       = (div_signed_s && src1_s[31]) ? (32'd0 - src1_s) : src1_s;
    assign abs2_s       = (div_signed_s && src2_s[31]) ? (32'd0 - src2_s) : src2_s;
    assign shifted_s    = {rem_r, quot_r[31]};
    assign trial_s      = shifted_s - {1'b0, divisor_r};
    assign quot_res_s   = quot_neg_r ? (32'd0 - quot_r) : quot_r;
    assign rem_res_s    = rem_neg_r ? (32'd0 - rem_r) : rem_r;

    // Divider FSM and shift-subtract datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 5'd0;
            rem_r      <= 32'd0;
            quot_r     <= 32'd0;
            divisor_r  <= 32'd0;
            quot_neg_r <= 1'b0;
            rem_neg_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (div_op_s && div_zero_s) begin
                        quot_r     <= 32'hFFFF_FFFF;
                        rem_r      <= src1_s;
                        quot_neg_r <= 1'b0;
                        rem_neg_r  <= 1'b0;
                        state_r    <= S_DONE;
                    end else if (div_op_s) begin
                        quot_r     <= abs1_s;
                        rem_r      <= 32'd0;
                        divisor_r  <= abs2_s;
                        quot_neg_r <= div_signed_s && (src1_s[31] ^ src2_s[31]);
                        rem_neg_r  <= div_signed_s && src1_s[31];
                        cnt_r      <= 5'd0;
                        state_r    <= S_RUN;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!trial_s[32]) begin
                        rem_r  <= trial_s[31:0];
                        quot_r <= {quot_r[30:0], 1'b1};
                    end else begin
                        rem_r  <= shifted_s[31:0];
                        quot_r <= {quot_r[30:0], 1'b0};
                    end
                    cnt_r   <= cnt_r + 5'd1;
                    state_r <= (cnt_r == 5'd31) ? S_DONE : S_RUN;
                end
                S_DONE:  state_r <= stall_s[3] ? S_DONE : S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // A divide-by-zero leaves EX before DONE, so a following MFHI/MFLO must see the result early.
    assign hi_rd_s = (state_r == S_DONE) ? rem_res_s  : hi_r;
    assign lo_rd_s = (state_r == S_DONE) ? quot_res_s : lo_r;

    // Next HI/LO: divider result first, then any move/multiply in the register overrides
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (state_r == S_DONE) begin
            hi_nxt_s = rem_res_s;
            lo_nxt_s = quot_res_s;
        end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
        end
        case (md_op_s)
            MD_MULT, MD_MULTU: {hi_nxt_s, lo_nxt_s} = prod_s;
            MD_MTHI:           hi_nxt_s = src1_s;
            MD_MTLO:           lo_nxt_s = src1_s;
            default:           begin end
        endcase
    end

    // HI/LO registers, written only when EX advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (!stall_s[3]) begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign ex_result_s = (md_op_s == MD_MFHI) ? hi_rd_s :
                         (md_op_s == MD_MFLO) ? lo_rd_s : alu_res_s;
    assign wen_s       = (mem_en_s && mem_we_s) ? 4'b1111 : 4'b0000;

    assign bus.data_sram_en    = mem_en_s;
    assign bus.data_sram_wen   = wen_s;
    assign bus.data_sram_addr  = sum_s;
    assign bus.data_sram_wdata = store_data_s;
    assign bus.ex_to_mem_bus   = {pc_s, mem_en_s, wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s, ex_result_s};
    assign bus.ex_to_id_bus    = {rf_we_s, rf_waddr_s, ex_result_s};
    assign bus.stallreq_for_ex = ((state_r == S_IDLE) && div_op_s && !div_zero_s) || (state_r == S_RUN);

    logic [EX_TO_MEM_WD-1:0] unused_width_s;
    assign unused_width_s = bus.ex_to_mem_bus;
endmodule
